// File: rtl/tdm_demux1b1to4_pkg.sv
// Shared types and constants for the 1-bit, 4-slot TDM demultiplexer.
// The slot counter and the top-level frame FSM both import this package.
package tdm_demux1b1to4_pkg;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FIRST_SLOT = slot_t'(0);
  localparam slot_t LAST_SLOT  = slot_t'(NSLOT - 1);

  function automatic logic isLastSlot(input slot_t s);
    return (s == LAST_SLOT);
  endfunction

endpackage

// File: rtl/tdm_demux1b1to4_slot_cnt2.sv
// Modulo-4 slot counter with clear, load-to-1 and count enable.
// Priority is clear, then load-to-1, then increment.
module slot_cnt2
  import tdm_demux1b1to4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  load1_i,
  input  logic  inc_i,
  output slot_t cnt_o
);

  slot_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = FIRST_SLOT;
    end else if (load1_i) begin
      cnt_d = slot_t'(1);
    end else if (inc_i) begin
      // Natural 2-bit overflow provides the 3 -> 0 wrap.
      cnt_d = cnt_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= FIRST_SLOT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux1b1to4.sv
// Serial TDM demultiplexer: aligns to a sync-marked frame of four 1-bit slots
// and presents the last complete frame on a..d with a one-cycle valid pulse.
module tdm_demux1b1to4
  import tdm_demux1b1to4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       sync,
  input  logic       en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [1:0] slot,
  output logic       frame_valid,
  output logic       sync_err
);

  state_e     state_q, state_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic       frameValid_q, frameValid_d;
  logic       syncErr_q, syncErr_d;
  logic       cntLoad1;
  logic       cntInc;
  slot_t      slotCur;

  slot_cnt2 u_slot_cnt2 (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .load1_i (cntLoad1),
    .inc_i   (cntInc),
    .cnt_o   (slotCur)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    frame_d      = frame_q;
    frameValid_d = 1'b0;
    syncErr_d    = 1'b0;
    cntLoad1     = 1'b0;
    cntInc       = 1'b0;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            shadow_d = {2'b00, din};
            cntLoad1 = 1'b1;
            state_d  = RUN;
          end
        end

        RUN: begin
          // A misplaced sync restarts the frame; the partial one is dropped.
          if (sync && (slotCur != FIRST_SLOT)) begin
            shadow_d  = {2'b00, din};
            cntLoad1  = 1'b1;
            syncErr_d = 1'b1;
          end else if (isLastSlot(slotCur)) begin
            frame_d      = {shadow_q[0], shadow_q[1], shadow_q[2], din};
            frameValid_d = 1'b1;
            cntInc       = 1'b1;
          end else begin
            case (slotCur)
              2'd0:    shadow_d[0] = din;
              2'd1:    shadow_d[1] = din;
              2'd2:    shadow_d[2] = din;
              default: shadow_d    = shadow_q;
            endcase
            cntInc = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      frame_q      <= '0;
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      frame_q      <= frame_d;
      frameValid_q <= frameValid_d;
      syncErr_q    <= syncErr_d;
    end
  end

  assign a           = frame_q[3];
  assign b           = frame_q[2];
  assign c           = frame_q[1];
  assign d           = frame_q[0];
  assign slot        = slotCur;
  assign frame_valid = frameValid_q;
  assign sync_err    = syncErr_q;

endmodule

// File: tb/tb_tdm_demux1b1to4.sv
// Directed self-checking bench for tdm_demux1b1to4.
// Inputs change 1 ns after each rising edge; outputs are sampled at that point too.
module tb_tdm_demux1b1to4;

  logic       clk;
  logic       rst;
  logic       din;
  logic       sync;
  logic       en;
  logic       a, b, c, d;
  logic [1:0] slot;
  logic       frameValid;
  logic       syncErr;

  int vecCount  = 0;
  int missCount = 0;

  tdm_demux1b1to4 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .sync        (sync),
    .en          (en),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .slot        (slot),
    .frame_valid (frameValid),
    .sync_err    (syncErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and return just after the edge that samples them.
  task automatic applyStimulus(input logic e, input logic s, input logic dIn);
    en   = e;
    sync = s;
    din  = dIn;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    en   = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en   = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    vecCount++;
    if ({a, b, c, d} !== 4'b0000) begin
      missCount++;
      $display("[TB] FAIL reset_abcd: got %b expected %b", {a, b, c, d}, 4'b0000);
    end
    vecCount++;
    if (slot !== 2'd0) begin
      missCount++;
      $display("[TB] FAIL reset_slot: got %0d expected 0", slot);
    end
    vecCount++;
    if ({frameValid, syncErr} !== 2'b00) begin
      missCount++;
      $display("[TB] FAIL reset_pulses: got fv/se=%b expected 00", {frameValid, syncErr});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    vecCount++;
    if (slot !== 2'd1) begin
      missCount++;
      $display("[TB] FAIL basic_slot_after_sync: got %0d expected 1", slot);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    vecCount++;
    if ((slot !== 2'd3) || (frameValid !== 1'b0)) begin
      missCount++;
      $display("[TB] FAIL basic_before_last: got slot=%0d fv=%b expected slot=3 fv=0", slot, frameValid);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if ({a, b, c, d, frameValid, slot} !== 7'b0101_1_00) begin
      missCount++;
      $display("[TB] FAIL basic_frame: got abcd=%b fv=%b slot=%0d expected abcd=0101 fv=1 slot=0",
               {a, b, c, d}, frameValid, slot);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    vecCount++;
    if ({a, b, c, d, frameValid} !== 5'b0101_0) begin
      missCount++;
      $display("[TB] FAIL basic_hold: got abcd=%b fv=%b expected abcd=0101 fv=0", {a, b, c, d}, frameValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int firstFv;
    int secondFv;
    bits     = 8'b0101_1110;
    firstFv  = -1;
    secondFv = -1;
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i == 0), bits[7-i]);
      if (frameValid === 1'b1) begin
        if (firstFv < 0) firstFv = i;
        else secondFv = i;
      end
      if (i == 3) begin
        vecCount++;
        if ({a, b, c, d} !== 4'b0101) begin
          missCount++;
          $display("[TB] FAIL b2b_first_frame: got %b expected 0101", {a, b, c, d});
        end
      end
    end
    vecCount++;
    if ((firstFv != 3) || (secondFv != 7)) begin
      missCount++;
      $display("[TB] FAIL b2b_fv_timing: got cycles %0d,%0d expected 3,7", firstFv, secondFv);
    end
    vecCount++;
    if ({a, b, c, d} !== 4'b1110) begin
      missCount++;
      $display("[TB] FAIL b2b_second_frame: got %b expected 1110", {a, b, c, d});
    end
  endtask

  task automatic test_en_gaps();
    int pulseCount;
    pulseCount = 0;
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    // While en is low, din and sync toggle and must be ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i != 1), (i == 1));
      if ((frameValid !== 1'b0) || (syncErr !== 1'b0) || (slot !== 2'd2)) pulseCount++;
    end
    vecCount++;
    if (pulseCount != 0) begin
      missCount++;
      $display("[TB] FAIL gap_quiet: got %0d bad idle cycles expected 0", pulseCount);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if ((frameValid !== 1'b0) || (slot !== 2'd3)) begin
      missCount++;
      $display("[TB] FAIL gap_slot3: got fv=%b slot=%0d expected fv=0 slot=3", frameValid, slot);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if ({a, b, c, d, frameValid} !== 5'b1111_1) begin
      missCount++;
      $display("[TB] FAIL gap_frame: got abcd=%b fv=%b expected abcd=1111 fv=1", {a, b, c, d}, frameValid);
    end
  endtask

  task automatic test_sync_err();
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    vecCount++;
    if ({syncErr, frameValid, slot, a, b, c, d} !== 8'b1_0_01_0101) begin
      missCount++;
      $display("[TB] FAIL serr_pulse: got se=%b fv=%b slot=%0d abcd=%b expected se=1 fv=0 slot=1 abcd=0101",
               syncErr, frameValid, slot, {a, b, c, d});
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    vecCount++;
    if ({syncErr, slot, a, b, c, d} !== 7'b0_10_0101) begin
      missCount++;
      $display("[TB] FAIL serr_one_cycle: got se=%b slot=%0d abcd=%b expected se=0 slot=2 abcd=0101",
               syncErr, slot, {a, b, c, d});
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if ({a, b, c, d, frameValid} !== 5'b1001_1) begin
      missCount++;
      $display("[TB] FAIL serr_realign: got abcd=%b fv=%b expected abcd=1001 fv=1", {a, b, c, d}, frameValid);
    end
  endtask

  task automatic test_no_sync();
    int badCount;
    badCount = 0;
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, i[0]);
      if ((slot !== 2'd0) || ({a, b, c, d} !== 4'b0000) || (frameValid !== 1'b0)) badCount++;
    end
    vecCount++;
    if (badCount != 0) begin
      missCount++;
      $display("[TB] FAIL nosync_idle: got %0d cycles with activity expected 0", badCount);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] bits;
    int pulseCount;
    bits       = 4'b1010;
    pulseCount = 0;
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    en  = 1'b0;
    rst = 1'b1;
    #2;
    vecCount++;
    if ({a, b, c, d, slot, frameValid, syncErr} !== 8'b0000_00_0_0) begin
      missCount++;
      $display("[TB] FAIL rstmid_async: got abcd=%b slot=%0d fv=%b se=%b expected all zero",
               {a, b, c, d}, slot, frameValid, syncErr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    vecCount++;
    if (slot !== 2'd0) begin
      missCount++;
      $display("[TB] FAIL rstmid_needs_sync: got slot=%0d expected 0", slot);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 0), bits[3-i]);
      if (frameValid === 1'b1) pulseCount++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (frameValid === 1'b1) pulseCount++;
    vecCount++;
    if (({a, b, c, d} !== 4'b1010) || (pulseCount != 1)) begin
      missCount++;
      $display("[TB] FAIL rstmid_frame: got abcd=%b pulses=%0d expected abcd=1010 pulses=1",
               {a, b, c, d}, pulseCount);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    #2;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_en_gaps();
    test_sync_err();
    test_no_sync();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/tdm_demux1b1to4.md
TDM_DEMUX1B1TO4 -- requirements
Module: tdm_demux1b1to4

Interface
REQ-001 SHALL have clock and reset as the first two ports.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 din  input  1  serial TDM data bit, one slot per enabled cycle.
REQ-005 sync  input  1  frame-start marker, qualified by en; marks din as slot 0.
REQ-006 en  input  1  slot strobe; when low, the cycle is ignored.
REQ-007 a,b,c,d  output  1 each  registered demuxed bits of slots 0,1,2,3 of the last complete frame.
REQ-008 slot  output  2  index of the slot the next enabled din is captured into.
REQ-009 frame_valid  output  1  one-cycle pulse: a..d just updated with a complete frame.
REQ-010 sync_err  output  1  one-cycle pulse: sync seen in RUN with slot != 0.

Function
REQ-011 States SHALL be IDLE (waiting for sync) and RUN (aligned to frame).
REQ-012 IDLE: en&sync SHALL capture din into shadow[0], set slot=1 and go to RUN; en without sync SHALL be discarded with slot held at 0.
REQ-013 RUN, en&~sync: din SHALL be captured into shadow[slot] and slot SHALL increment modulo 4.
REQ-014 RUN, en&sync with slot==0: normal slot-0 capture, no error.
REQ-015 RUN, en&sync with slot!=0: the partial frame SHALL be discarded; din SHALL be captured as slot 0; slot becomes 1; sync_err SHALL pulse on the next cycle; a..d SHALL be unchanged.
REQ-016 Capture of slot 3: a,b,c SHALL load shadow[0..2] and d SHALL load din on the same edge; frame_valid SHALL be high for exactly the following cycle; slot wraps to 0.
REQ-017 Latency: a..d and frame_valid SHALL update on the edge that samples the slot-3 bit (0 cycles after the last bit edge, visible the next cycle).
REQ-018 en low: no state, slot, shadow or output change; frame_valid and sync_err SHALL be 0.
REQ-019 a..d SHALL hold their value between frame_valid pulses.
REQ-020 Slot wrap 3->0 SHALL NOT require sync; back-to-back frames SHALL produce frame_valid every 4 enabled cycles.
REQ-021 din, sync SHALL be ignored when en is low, including sync.

Reset
REQ-022 rst high SHALL immediately force state=IDLE, slot=0, shadow=0, a=b=c=d=0, frame_valid=0, sync_err=0.
REQ-023 Reset mid-frame SHALL discard the partial frame; after release, a sync is required before any capture.

Structure
REQ-024 Shared package SHALL hold the state enum (IDLE, RUN) and constant NSLOT=4 with slot width 2.
REQ-025 The modulo-4 slot counter (enable, load-to-1, clear) SHALL be one sub-module: slot_cnt2.

Verification
REQ-026 Reset then en=1 for 4 cycles, sync on first, din=0,1,0,1 -> a=0 b=1 c=0 d=1, frame_valid high one cycle, slot=0.
REQ-027 Two back-to-back frames 0101 then 1110 with sync only on first -> second frame_valid 4 cycles after first; a=1 b=1 c=1 d=0.
REQ-028 Frame 1111 with en low for 3 cycles between slots 1 and 2 -> frame_valid delayed 3 cycles; a..d=1111; no pulses while en low.
REQ-029 After frame 0101, sync at slot 2 with din=1 then 0,0,1 -> sync_err one cycle; a..d stay 0101 until next frame_valid, then 1001.
REQ-030 en=1, din toggling, no sync, from reset -> slot stays 0, a..d=0, no frame_valid.
REQ-031 rst asserted after slot 2 capture, then full frame 1010 with sync -> outputs 0 during reset, then a=1 b=0 c=1 d=0 with single frame_valid.
